// File: rtl/ex_muldiv_pkg.sv
// Shared constants, FSM encoding and operand-signedness helpers for the M-extension unit.
package ex_muldiv_pkg;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;
    localparam logic [6:0] M_FUNCT7  = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'd0;
    localparam logic [2:0] INST_MULH   = 3'd1;
    localparam logic [2:0] INST_MULHSU = 3'd2;
    localparam logic [2:0] INST_MULHU  = 3'd3;
    localparam logic [2:0] INST_DIV    = 3'd4;
    localparam logic [2:0] INST_DIVU   = 3'd5;
    localparam logic [2:0] INST_REM    = 3'd6;
    localparam logic [2:0] INST_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // All divide/remainder ops have funct3[2] set
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic op1_signed(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_MULHSU) || (f3 == INST_DIV) || (f3 == INST_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_DIV) || (f3 == INST_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step.
// acc holds {high/remainder, low/quotient}.
module ex_muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next_c
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Multiply adds into the high half then shifts right; divide shifts left and trial-subtracts
    always_comb begin
        add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        shifted = acc[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, operand};
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_next_c = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next_c = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next_c = {add_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with flush abort.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   acc_next;
    logic [XLEN-1:0]     mag2;
    logic [2:0]          funct3_q;
    logic [4:0]          rd_q;
    logic                neg1_q, neg2_q;

    logic                accept;
    logic                neg1, neg2;
    logic [XLEN-1:0]     mag1_in, mag2_in;
    logic                div_zero, div_ovf;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_result;

    ex_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div     (is_div_op(funct3_q)),
        .acc        (acc),
        .operand    (mag2),
        .acc_next_c (acc_next)
    );

    // Request decode: operand magnitudes and division fast-path detection
    always_comb begin
        accept   = (state == ST_IDLE) && start_i && !flush_i;
        neg1     = op1_signed(funct3_i) && op1_i[XLEN-1];
        neg2     = op2_signed(funct3_i) && op2_i[XLEN-1];
        mag1_in  = neg1 ? (-op1_i) : op1_i;
        mag2_in  = neg2 ? (-op2_i) : op2_i;
        div_zero = is_div_op(funct3_i) && (op2_i == '0);
        div_ovf  = ((funct3_i == INST_DIV) || (funct3_i == INST_REM))
                   && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept) state_next = (div_zero || div_ovf) ? ST_FIX : ST_CALC;
            ST_CALC: if (flush_i) state_next = ST_IDLE;
                     else if (cnt == CNT_LAST) state_next = ST_FIX;
            ST_FIX:  state_next = flush_i ? ST_IDLE : ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture and iteration; fast paths preload final unsigned results with no sign fix
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            acc      <= '0;
            mag2     <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            mag2     <= mag2_in;
            funct3_q <= funct3_i;
            rd_q     <= rd_addr_i;
            if (div_zero) begin
                acc    <= {op1_i, {XLEN{1'b1}}};
                neg1_q <= 1'b0;
                neg2_q <= 1'b0;
            end else if (div_ovf) begin
                acc    <= {{XLEN{1'b0}}, op1_i};
                neg1_q <= 1'b0;
                neg2_q <= 1'b0;
            end else begin
                acc    <= {{XLEN{1'b0}}, mag1_in};
                neg1_q <= neg1;
                neg2_q <= neg2;
            end
        end else if (state == ST_CALC) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Sign correction and result selection
    always_comb begin
        prod_fix   = (neg1_q ^ neg2_q) ? (-acc) : acc;
        quo_fix    = (neg1_q ^ neg2_q) ? (-acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem_fix    = neg1_q ? (-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        fix_result = prod_fix[XLEN-1:0];
        unique case (funct3_q)
            INST_MUL:                         fix_result = prod_fix[XLEN-1:0];
            INST_MULH, INST_MULHSU, INST_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            INST_DIV, INST_DIVU:              fix_result = quo_fix;
            default:                          fix_result = rem_fix;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_o    <= 1'b0;
            valid_o   <= 1'b0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else begin
            busy_o  <= (state_next == ST_CALC) || (state_next == ST_FIX);
            valid_o <= (state == ST_FIX) && !flush_i;
            if ((state == ST_FIX) && !flush_i) begin
                result_o  <= fix_result;
                rd_addr_o <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv at XLEN=32.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int NORM_LAT = XLEN + 2;
    localparam int FAST_LAT = 2;

    logic            clk;
    logic            rstn;
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .funct3_i  (funct3_i),
        .op1_i     (op1_i),
        .op2_i     (op2_i),
        .rd_addr_i (rd_addr_i),
        .flush_i   (flush_i),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .rd_addr_o (rd_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op at the current negedge and watch lat+3 cycles; optionally pulse stray starts
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int lat, input bit noise);
        int vcyc;
        int nvalid;
        int bad_busy;
        logic [31:0] res_at_valid;
        logic [4:0]  rd_at_valid;
        vcyc = -1; nvalid = 0; bad_busy = 0;
        res_at_valid = '0; rd_at_valid = '0;
        funct3_i = f3; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
        for (int k = 1; k <= lat + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
            if (busy_o !== 1'(k < lat)) bad_busy++;
            if (valid_o === 1'b1) begin
                nvalid++;
                if (vcyc < 0) begin
                    vcyc = k;
                    res_at_valid = result_o;
                    rd_at_valid = rd_addr_o;
                end
            end
            if (noise && (k == 5 || k == 20 || k == lat)) begin
                start_i = 1'b1; funct3_i = INST_DIVU; op1_i = 32'd9; op2_i = 32'd0; rd_addr_i = 5'd31;
            end
        end
        check({tag, "_latency"}, 64'(vcyc), 64'(lat));
        check({tag, "_nvalid"}, 64'(nvalid), 64'd1);
        check({tag, "_busy"}, 64'(bad_busy), 64'd0);
        check({tag, "_result"}, 64'(res_at_valid), 64'(exp));
        check({tag, "_rd"}, 64'(rd_at_valid), 64'(rd));
        check({tag, "_hold"}, 64'(result_o), 64'(exp));
    endtask

    initial begin
        int vseen;
        rstn = 1'b0; start_i = 1'b0; funct3_i = '0; op1_i = '0; op2_i = '0;
        rd_addr_i = '0; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_rd", 64'(rd_addr_o), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        run_op("mul",    INST_MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, NORM_LAT, 1'b1);
        run_op("mulh",   INST_MULH,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000, NORM_LAT, 1'b0);
        run_op("mulhu",  INST_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, NORM_LAT, 1'b0);
        run_op("mulhsu", INST_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, NORM_LAT, 1'b0);
        run_op("div",    INST_DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, NORM_LAT, 1'b0);
        run_op("rem",    INST_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, NORM_LAT, 1'b0);
        run_op("divu",   INST_DIVU,   32'd100,      32'd7,        5'd9,  32'd14,       NORM_LAT, 1'b0);
        run_op("remu",   INST_REMU,   32'd100,      32'd7,        5'd10, 32'd2,        NORM_LAT, 1'b0);
        run_op("div0",   INST_DIV,    32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, FAST_LAT, 1'b0);
        run_op("remu0",  INST_REMU,   32'd5,        32'd0,        5'd12, 32'd5,        FAST_LAT, 1'b0);
        run_op("divovf", INST_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, FAST_LAT, 1'b0);
        run_op("removf", INST_REM,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        FAST_LAT, 1'b0);

        // Flush a DIV in c+10; previous result (0) must stay and no strobe appears
        vseen = 0;
        funct3_i = INST_DIV; op1_i = 32'd1000; op2_i = 32'd3; rd_addr_i = 5'd15; start_i = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
            if (valid_o === 1'b1) vseen++;
            if (k == 10) flush_i = 1'b1;
            if (k == 11) flush_i = 1'b0;
        end
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_novalid", 64'(vseen), 64'd0);
        check("flush_result", 64'(result_o), 64'd0);
        run_op("post_flush", INST_DIVU, 32'd100, 32'd7, 5'd16, 32'd14, NORM_LAT, 1'b0);

        // Asynchronous reset mid-MUL clears outputs at once
        funct3_i = INST_MUL; op1_i = 32'd3; op2_i = 32'd5; rd_addr_i = 5'd17; start_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
        end
        rstn = 1'b0;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_valid", 64'(valid_o), 64'd0);
        check("arst_result", 64'(result_o), 64'd0);
        check("arst_rd", 64'(rd_addr_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_op("post_rst", INST_MUL, 32'd12345, 32'd678, 5'd18, 32'd8369910, NORM_LAT, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
